spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter_if.sv | 27 ++
 rtl/spi_arbiter.sv | 116 +++++++++++
 tb/tb_spi_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester, response and SPI-engine signals of the two-requester SPI arbiter.
interface spi_arbiter_if;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_last, req1_last;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_err, rsp1_err;
  logic       spi_start;
  logic [7:0] spi_data_tx;
  logic [7:0] spi_data_rx;
  logic       spi_busy;
  logic [1:0] cs_n;
  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last,
    output spi_data_rx, spi_busy,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    input  rsp0_err, rsp1_err, spi_start, spi_data_tx, cs_n
  );
  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last,
    input  spi_data_rx, spi_busy,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    output rsp0_err, rsp1_err, spi_start, spi_data_tx, cs_n
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI engine between two byte-stream requesters
module spi_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD = 2,
  parameter int START_TIMEOUT = 255
) (
  input logic raw_clk,
  input logic reset,
  spi_arbiter_if.slave bus
);
  localparam int MX = START_TIMEOUT > CS_SETUP ? (START_TIMEOUT > CS_HOLD ? START_TIMEOUT : CS_HOLD)
                                               : (CS_SETUP > CS_HOLD ? CS_SETUP : CS_HOLD);
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, SETUP, WAIT_DATA, START, XFER, HOLD} state_t;
  state_t state, state_nxt;
  logic grant, grant_nxt, last_grant, last_grant_nxt, last_byte, last_byte_nxt, start, start_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] cs, cs_nxt, rsp_v, rsp_v_nxt, rsp_e, rsp_e_nxt, vld;
  logic [1:0][7:0] rsp_d, rsp_d_nxt;
  logic [7:0] tx, tx_nxt;
  assign vld = {bus.req1_valid, bus.req0_valid};
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      last_byte <= 1'b0;
      start <= 1'b0;
      cnt <= '0;
      cs <= 2'b11;
      rsp_v <= 2'b00;
      rsp_e <= 2'b00;
      rsp_d <= '0;
      tx <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last_grant <= last_grant_nxt;
      last_byte <= last_byte_nxt;
      start <= start_nxt;
      cnt <= cnt_nxt;
      cs <= cs_nxt;
      rsp_v <= rsp_v_nxt;
      rsp_e <= rsp_e_nxt;
      rsp_d <= rsp_d_nxt;
      tx <= tx_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_grant_nxt = last_grant;
    last_byte_nxt = last_byte;
    start_nxt = start;
    cnt_nxt = cnt;
    cs_nxt = cs;
    rsp_v_nxt = 2'b00;
    rsp_e_nxt = 2'b00;
    rsp_d_nxt = rsp_d;
    tx_nxt = tx;
    case (state)
      IDLE: if (!bus.spi_busy && |vld) begin
        grant_nxt = vld == 2'b11 ? !last_grant : vld[1];
        cs_nxt = grant_nxt ? 2'b01 : 2'b10;
        cnt_nxt = '0;
        state_nxt = SETUP;
      end
      SETUP: if (cnt == CW'(CS_SETUP - 1)) begin
        cnt_nxt = '0;
        state_nxt = WAIT_DATA;
      end else cnt_nxt = cnt + 1'b1;
      WAIT_DATA: if (vld[grant]) begin
        tx_nxt = grant ? bus.req1_data : bus.req0_data;
        last_byte_nxt = grant ? bus.req1_last : bus.req0_last;
        start_nxt = 1'b1;
        cnt_nxt = '0;
        state_nxt = START;
      end
      START: if (bus.spi_busy) begin
        start_nxt = 1'b0;
        state_nxt = XFER;
      end else if (cnt == CW'(START_TIMEOUT - 1)) begin
        // engine never answered: report the error and give up the grant regardless of last
        start_nxt = 1'b0;
        rsp_v_nxt[grant] = 1'b1;
        rsp_e_nxt[grant] = 1'b1;
        rsp_d_nxt[grant] = '0;
        cnt_nxt = '0;
        state_nxt = HOLD;
      end else cnt_nxt = cnt + 1'b1;
      XFER: if (!bus.spi_busy) begin
        rsp_v_nxt[grant] = 1'b1;
        rsp_d_nxt[grant] = bus.spi_data_rx;
        cnt_nxt = '0;
        state_nxt = last_byte ? HOLD : WAIT_DATA;
      end
      HOLD: if (cnt == CW'(CS_HOLD - 1)) begin
        cs_nxt = 2'b11;
        last_grant_nxt = grant;
        state_nxt = IDLE;
      end else cnt_nxt = cnt + 1'b1;
      default: state_nxt = IDLE;
    endcase
  end
  assign bus.req0_ready = state == WAIT_DATA && !grant;
  assign bus.req1_ready = state == WAIT_DATA && grant;
  assign bus.rsp0_valid = rsp_v[0];
  assign bus.rsp1_valid = rsp_v[1];
  assign bus.rsp0_err = rsp_e[0];
  assign bus.rsp1_err = rsp_e[1];
  assign bus.rsp0_data = rsp_d[0];
  assign bus.rsp1_data = rsp_d[1];
  assign bus.spi_start = start;
  assign bus.spi_data_tx = tx;
  assign bus.cs_n = cs;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed bench with a transaction-level arbiter model and a nibble-swapping SPI engine.
module tb_spi_arbiter;
  logic raw_clk = 1'b0;
  logic reset;
  logic eng_on, eng_busy, man_busy;
  int checks = 0, failures = 0;
  int cyc = 0, st_cnt = 0, start_len = 0, rsp_cyc = 0, hold_dist = 0;
  logic m_last, holder, e_g, prev_start, prev_act;
  logic [1:0] prev_cs, prev_vld;
  logic [7:0] prev_tx;
  logic [8:0] q0[$], q1[$];
  int gq[$];
  spi_arbiter_if bus();
  spi_arbiter #(.CS_SETUP(2), .CS_HOLD(2), .START_TIMEOUT(255)) dut (
    .raw_clk(raw_clk), .reset(reset), .bus(bus)
  );
  assign bus.spi_busy = eng_busy | man_busy;
  always #5 raw_clk = ~raw_clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  // SPI engine: busy rises two cycles after a start is seen, lasts four cycles, returns the nibble-swapped byte
  initial begin
    logic [7:0] t;
    eng_busy = 1'b0;
    bus.spi_data_rx = 8'h00;
    forever begin
      @(posedge raw_clk); #1;
      if (eng_on && !reset && bus.spi_start && !bus.spi_busy) begin
        t = bus.spi_data_tx;
        repeat (2) @(posedge raw_clk);
        #1 eng_busy = 1'b1;
        repeat (4) @(posedge raw_clk);
        #1 bus.spi_data_rx = {t[3:0], t[7:4]};
        eng_busy = 1'b0;
      end
    end
  end
  // reference model: round-robin grant order, response queues, protocol invariants
  initial begin
    logic act;
    m_last = 1'b1;
    holder = 1'b0;
    prev_cs = 2'b11;
    prev_vld = 2'b00;
    prev_start = 1'b0;
    prev_act = 1'b0;
    prev_tx = 8'h00;
    forever begin
      @(negedge raw_clk);
      cyc++;
      act = bus.spi_start | bus.spi_busy;
      if (reset) begin
        m_last = 1'b1;
        st_cnt = 0;
      end else begin
        check("cs_both_low", bus.cs_n == 2'b00, 0);
        check("ready0_without_cs", bus.req0_ready & bus.cs_n[0], 0);
        check("ready1_without_cs", bus.req1_ready & bus.cs_n[1], 0);
        check("rsp_overlap", bus.rsp0_valid & bus.rsp1_valid, 0);
        check("start_without_cs", bus.spi_start & (bus.cs_n == 2'b11), 0);
        if (prev_act && act) check("tx_stable", bus.spi_data_tx, prev_tx);
        if (prev_cs == 2'b11 && bus.cs_n != 2'b11) begin
          holder = bus.cs_n[0];
          e_g = prev_vld == 2'b11 ? !m_last : prev_vld[1];
          check("grant", holder, e_g);
          gq.push_back(int'(holder));
        end else if (prev_cs != 2'b11 && bus.cs_n == 2'b11) begin
          m_last = holder;
          hold_dist = cyc - rsp_cyc;
        end else if (prev_cs != 2'b11) check("cs_stable", bus.cs_n, prev_cs);
        if (bus.rsp0_valid) begin
          check("rsp0_pending", q0.size() != 0, 1);
          if (q0.size() != 0) check("rsp0", {bus.rsp0_err, bus.rsp0_data}, q0.pop_front());
          rsp_cyc = cyc;
        end
        if (bus.rsp1_valid) begin
          check("rsp1_pending", q1.size() != 0, 1);
          if (q1.size() != 0) check("rsp1", {bus.rsp1_err, bus.rsp1_data}, q1.pop_front());
          rsp_cyc = cyc;
        end
        if (bus.spi_start) st_cnt++;
        else if (prev_start) begin
          start_len = st_cnt;
          st_cnt = 0;
        end
      end
      prev_cs = bus.cs_n;
      prev_vld = {bus.req1_valid, bus.req0_valid};
      prev_start = bus.spi_start & !reset;
      prev_act = act & !reset;
      prev_tx = bus.spi_data_tx;
    end
  end
  task automatic send(input bit n, input logic [7:0] d, input bit l, input logic [8:0] e);
    bit ok = 0;
    if (n) begin
      q1.push_back(e);
      bus.req1_data = d; bus.req1_last = l; bus.req1_valid = 1'b1;
    end else begin
      q0.push_back(e);
      bus.req0_data = d; bus.req0_last = l; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge raw_clk);
      if (n ? bus.req1_ready : bus.req0_ready) begin
        ok = 1;
        break;
      end
    end
    check(n ? "send1_ready" : "send0_ready", ok, 1);
    @(posedge raw_clk); #1;
    if (n) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge raw_clk);
      if (bus.cs_n == 2'b11) begin
        ok = 1;
        break;
      end
    end
    check("cs_release", ok, 1);
    @(posedge raw_clk); #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge raw_clk);
    #1 reset = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok;
    reset = 1'b1;
    eng_on = 1'b1;
    man_busy = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
    repeat (3) @(posedge raw_clk);
    @(negedge raw_clk);
    check("rst_cs_n", bus.cs_n, 2'b11);
    check("rst_spi_start", bus.spi_start, 0);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_rsp0_valid", bus.rsp0_valid, 0);
    check("rst_rsp1_valid", bus.rsp1_valid, 0);
    check("rst_rsp0_err", bus.rsp0_err, 0);
    check("rst_rsp0_data", bus.rsp0_data, 0);
    check("rst_rsp1_data", bus.rsp1_data, 0);
    check("rst_spi_data_tx", bus.spi_data_tx, 0);
    @(posedge raw_clk); #1 reset = 1'b0;
    // single two-byte burst from requester 0
    send(0, 8'hA5, 0, {1'b0, 8'h5A});
    send(0, 8'h3C, 1, {1'b0, 8'hC3});
    wait_idle();
    check("burst_hold_cycles", hold_dist, 2);
    check("burst_start_len", start_len, 3);
    check("burst_rsp0_drained", q0.size(), 0);
    // contention after reset, then again with last_grant=1
    do_reset();
    gq.delete();
    fork
      send(0, 8'h01, 1, {1'b0, 8'h10});
      send(1, 8'h02, 1, {1'b0, 8'h20});
    join
    wait_idle();
    fork
      send(0, 8'h03, 1, {1'b0, 8'h30});
      send(1, 8'h04, 1, {1'b0, 8'h40});
    join
    wait_idle();
    check("rr_grants", gq.size(), 4);
    if (gq.size() == 4) begin
      check("rr_grant0", gq[0], 0);
      check("rr_grant1", gq[1], 1);
      check("rr_grant2", gq[2], 0);
      check("rr_grant3", gq[3], 1);
    end
    // start timeout: engine silent
    eng_on = 1'b0;
    send(0, 8'h11, 0, {1'b1, 8'h00});
    wait_idle();
    check("timeout_start_len", start_len, 255);
    check("timeout_hold_cycles", hold_dist, 2);
    check("timeout_rsp0_drained", q0.size(), 0);
    eng_on = 1'b1;
    // requester 1 stalls 50 cycles mid-burst while requester 0 waits
    fork
      begin
        send(1, 8'h42, 0, {1'b0, 8'h24});
        repeat (50) @(posedge raw_clk);
        #1;
        check("stall_cs_n", bus.cs_n, 2'b01);
        check("stall_ready0", bus.req0_ready, 0);
        send(1, 8'h24, 1, {1'b0, 8'h42});
      end
      begin
        repeat (10) @(posedge raw_clk);
        #1 send(0, 8'h99, 1, {1'b0, 8'h99});
      end
    join
    wait_idle();
    // reset while the engine is busy: burst abandoned, no regrant until busy drops
    eng_on = 1'b0;
    bus.req0_data = 8'h5E; bus.req0_last = 1'b1; bus.req0_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge raw_clk);
      if (bus.req0_ready) begin
        ok = 1;
        break;
      end
    end
    check("rst_xfer_accept", ok, 1);
    @(posedge raw_clk); #1;
    bus.req0_valid = 1'b0;
    man_busy = 1'b1;
    repeat (2) @(posedge raw_clk);
    #1 reset = 1'b1;
    @(posedge raw_clk);
    @(negedge raw_clk);
    check("rst_xfer_cs_n", bus.cs_n, 2'b11);
    check("rst_xfer_start", bus.spi_start, 0);
    check("rst_xfer_rsp0", bus.rsp0_valid, 0);
    @(posedge raw_clk); #1 reset = 1'b0;
    bus.req0_data = 8'h71; bus.req0_last = 1'b1; bus.req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge raw_clk);
      check("busy_blocks_grant", bus.cs_n, 2'b11);
    end
    @(posedge raw_clk); #1;
    man_busy = 1'b0;
    eng_on = 1'b1;
    send(0, 8'h71, 1, {1'b0, 8'h17});
    wait_idle();
    check("end_rsp0_drained", q0.size(), 0);
    check("end_rsp1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
